// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: shared addressing-mode/FSM enums, opcode constants and argument-count helper
package ssd1306_pkg;
  localparam int COLS_DEF = 128;
  localparam int PAGES_DEF = 8;
  typedef enum logic [1:0] {HORIZ = 2'b00, VERT = 2'b01, PAGE = 2'b10} mode_t;
  typedef enum logic [1:0] {CMD, ARG1, ARG2} state_t;
  localparam logic [7:0] OP_SET_MODE    = 8'h20;
  localparam logic [7:0] OP_COL_ADDR    = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] OP_OFFSET      = 8'hD3;
  localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
  localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
  localparam logic [7:0] OP_COM_PINS    = 8'hDA;
  localparam logic [7:0] OP_VCOMH       = 8'hDB;
  localparam logic [7:0] OP_ALL_OFF     = 8'hA4;
  localparam logic [7:0] OP_ALL_ON      = 8'hA5;
  localparam logic [7:0] OP_NORMAL      = 8'hA6;
  localparam logic [7:0] OP_INVERT      = 8'hA7;
  localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
  localparam logic [7:0] OP_DISP_ON     = 8'hAF;
  function automatic logic [1:0] op_args(input logic [7:0] op);
    return (op == OP_COL_ADDR || op == OP_PAGE_ADDR) ? 2'd2 :
           (op inside {OP_SET_MODE, OP_CONTRAST, OP_CHARGE_PUMP, OP_MUX_RATIO, OP_OFFSET,
                       OP_CLK_DIV, OP_PRECHARGE, OP_COM_PINS, OP_VCOMH}) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/ssd1306_addr_gen.sv
// ssd1306_addr_gen: col/page pointers, windows and mode; advances on adv, loads on set_* strobes from val
module ssd1306_addr_gen
  import ssd1306_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int PAGES = PAGES_DEF
) (
  input  logic                       CLK25MHz,
  input  logic                       reset,
  input  logic                       adv,
  input  logic                       set_lo,
  input  logic                       set_hi,
  input  logic                       set_page,
  input  logic                       set_mode,
  input  logic                       set_cs,
  input  logic                       set_ce,
  input  logic                       set_ps,
  input  logic                       set_pe,
  input  logic [7:0]                 val,
  output logic [$clog2(COLS)-1:0]    col,
  output logic [$clog2(PAGES)-1:0]   page
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  mode_t mode;
  logic [CW-1:0] cs, ce, col_nx;
  logic [PW-1:0] ps, pe, page_nx;
  logic col_wrap, page_wrap;
  assign col_wrap = col == ce;
  assign page_wrap = page == pe;
  assign col_nx = col_wrap ? cs : col + CW'(1);
  assign page_nx = page_wrap ? ps : page + PW'(1);
  always_ff @(posedge CLK25MHz) begin
    if (reset) begin
      mode <= PAGE;
      col <= '0;
      page <= '0;
      cs <= '0;
      ce <= '1;
      ps <= '0;
      pe <= '1;
    end else begin
      if (adv) begin
        col <= mode == PAGE ? col + CW'(1) : (mode == HORIZ || page_wrap) ? col_nx : col;
        page <= (mode == VERT || (mode == HORIZ && col_wrap)) ? page_nx : page;
      end
      if (set_lo) col[3:0] <= val[3:0];
      if (set_hi) col[6:4] <= val[2:0];
      if (set_page) page <= val[PW-1:0];
      if (set_mode) mode <= mode_t'(val[1:0]);
      if (set_cs) begin
        cs <= val[CW-1:0];
        col <= val[CW-1:0];
      end
      if (set_ce) ce <= val[CW-1:0];
      if (set_ps) begin
        ps <= val[PW-1:0];
        page <= val[PW-1:0];
      end
      if (set_pe) pe <= val[PW-1:0];
    end
  end
endmodule

// File: rtl/ssd1306_cmd_ctrl.sv
// ssd1306_cmd_ctrl: decodes DC-tagged bytes (in_*) into framebuffer writes (fb_*) and display flags (disp_*, contrast)
module ssd1306_cmd_ctrl
  import ssd1306_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int PAGES = PAGES_DEF,
  parameter logic [7:0] CONTRAST_RST = 8'h7F
) (
  input  logic       CLK25MHz,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_dc,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       fb_we,
  output logic [9:0] fb_waddr,
  output logic [7:0] fb_wdata,
  output logic       disp_on,
  output logic       disp_invert,
  output logic       disp_all_on,
  output logic [7:0] contrast
);
  state_t state;
  logic [7:0] op;
  logic [$clog2(COLS)-1:0] col;
  logic [$clog2(PAGES)-1:0] page;
  logic dat, c0, a1, a2;
  assign in_ready = !reset;
  assign dat = in_valid && in_dc;
  assign c0 = in_valid && !in_dc && state == CMD;
  assign a1 = in_valid && !in_dc && state == ARG1;
  assign a2 = in_valid && !in_dc && state == ARG2;
  ssd1306_addr_gen #(.COLS(COLS), .PAGES(PAGES)) u_addr (
    .CLK25MHz(CLK25MHz),
    .reset(reset),
    .adv(dat),
    .set_lo(c0 && in_data[7:4] == 4'h0),
    .set_hi(c0 && in_data[7:4] == 4'h1),
    .set_page(c0 && in_data[7:3] == 5'b10110),
    .set_mode(a1 && op == OP_SET_MODE && in_data[1:0] != 2'b11),
    .set_cs(a1 && op == OP_COL_ADDR),
    .set_ce(a2 && op == OP_COL_ADDR),
    .set_ps(a1 && op == OP_PAGE_ADDR),
    .set_pe(a2 && op == OP_PAGE_ADDR),
    .val(in_data),
    .col(col),
    .page(page)
  );
  always_ff @(posedge CLK25MHz) begin
    if (reset) begin
      state <= CMD;
      op <= '0;
      fb_we <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
      disp_on <= 1'b0;
      disp_invert <= 1'b0;
      disp_all_on <= 1'b0;
      contrast <= CONTRAST_RST;
    end else begin
      fb_we <= dat;
      if (dat) begin
        fb_waddr <= 10'({page, col});
        fb_wdata <= in_data;
        state <= CMD;
      end
      if (c0) begin
        disp_on <= in_data == OP_DISP_ON ? 1'b1 : in_data == OP_DISP_OFF ? 1'b0 : disp_on;
        disp_invert <= in_data == OP_INVERT ? 1'b1 : in_data == OP_NORMAL ? 1'b0 : disp_invert;
        disp_all_on <= in_data == OP_ALL_ON ? 1'b1 : in_data == OP_ALL_OFF ? 1'b0 : disp_all_on;
        if (op_args(in_data) != 2'd0) begin
          op <= in_data;
          state <= ARG1;
        end
      end
      if (a1) begin
        if (op == OP_CONTRAST) contrast <= in_data;
        state <= op_args(op) == 2'd2 ? ARG2 : CMD;
      end
      if (a2) state <= CMD;
    end
  end
endmodule

// File: tb/tb_ssd1306_cmd_ctrl.sv
// tb_ssd1306_cmd_ctrl: scenario tasks plus randomized byte stream checked against a byte-level interpreter model
module tb_ssd1306_cmd_ctrl;
  logic CLK25MHz = 0, reset = 1, in_valid = 0, in_dc = 0;
  logic [7:0] in_data = 0;
  logic in_ready, fb_we, disp_on, disp_invert, disp_all_on;
  logic [9:0] fb_waddr;
  logic [7:0] fb_wdata, contrast;
  int nchk = 0, nerr = 0;
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode, m_con, pend, argn;
  bit m_on, m_inv, m_all, exp_we;
  logic [9:0] exp_addr;
  logic [7:0] exp_data;

  ssd1306_cmd_ctrl dut (
    .CLK25MHz(CLK25MHz), .reset(reset), .in_valid(in_valid), .in_dc(in_dc), .in_data(in_data),
    .in_ready(in_ready), .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
    .disp_on(disp_on), .disp_invert(disp_invert), .disp_all_on(disp_all_on), .contrast(contrast)
  );

  always #20 CLK25MHz = ~CLK25MHz;

  function automatic int winc(int p, int s, int e, int size);
    return p == e ? s : (p + 1) % size;
  endfunction

  function automatic int nargs(int b);
    if (b == 'h21 || b == 'h22) return 2;
    if (b inside {'h20, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB}) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_mode = 2;
    m_con = 'h7F; m_on = 0; m_inv = 0; m_all = 0; argn = 0; pend = 0; exp_we = 0;
  endfunction

  function automatic void model_byte(bit dc, int b);
    bit w;
    exp_we = 0;
    if (dc) begin
      exp_we = 1;
      exp_addr = 10'(m_page * 128 + m_col);
      exp_data = 8'(b);
      argn = 0;
      if (m_mode == 0) begin
        w = m_col == m_ce;
        m_col = winc(m_col, m_cs, m_ce, 128);
        if (w) m_page = winc(m_page, m_ps, m_pe, 8);
      end else if (m_mode == 1) begin
        w = m_page == m_pe;
        m_page = winc(m_page, m_ps, m_pe, 8);
        if (w) m_col = winc(m_col, m_cs, m_ce, 128);
      end else m_col = (m_col + 1) % 128;
    end else if (argn == 0) begin
      if (b < 16) m_col = (m_col & 'h70) | b;
      else if (b < 32) m_col = (m_col & 'h0F) | ((b & 7) << 4);
      else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
      else if (b == 'hAF) m_on = 1;
      else if (b == 'hAE) m_on = 0;
      else if (b == 'hA7) m_inv = 1;
      else if (b == 'hA6) m_inv = 0;
      else if (b == 'hA5) m_all = 1;
      else if (b == 'hA4) m_all = 0;
      if (nargs(b) > 0) begin
        pend = b;
        argn = 1;
      end
    end else if (argn == 1) begin
      if (pend == 'h20 && (b & 3) != 3) m_mode = b & 3;
      if (pend == 'h81) m_con = b;
      if (pend == 'h21) begin m_cs = b & 127; m_col = m_cs; end
      if (pend == 'h22) begin m_ps = b & 7; m_page = m_ps; end
      argn = (pend == 'h21 || pend == 'h22) ? 2 : 0;
    end else begin
      if (pend == 'h21) m_ce = b & 127;
      if (pend == 'h22) m_pe = b & 7;
      argn = 0;
    end
  endfunction

  task automatic push(input bit dc, input logic [7:0] b);
    @(negedge CLK25MHz);
    in_valid = 1; in_dc = dc; in_data = b;
    model_byte(dc, int'(b));
    @(posedge CLK25MHz);
    #1 in_valid = 0;
  endtask

  task automatic idle();
    @(negedge CLK25MHz);
    in_valid = 0;
    exp_we = 0;
    @(posedge CLK25MHz);
    #1;
  endtask

  task automatic hold_reset(input int n);
    @(negedge CLK25MHz);
    reset = 1; in_valid = 0;
    model_reset();
    repeat (n) @(posedge CLK25MHz);
    #1;
  endtask

  task automatic release_reset();
    @(negedge CLK25MHz);
    reset = 0;
  endtask

  task automatic test_reset();
    hold_reset(2);
    nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready got %b exp 0", in_ready); end
    nchk++; if (fb_we !== 1'b0) begin nerr++; $display("FAIL rst_we got %b exp 0", fb_we); end
    nchk++; if (fb_waddr !== 10'h0) begin nerr++; $display("FAIL rst_addr got %h exp 000", fb_waddr); end
    nchk++; if (fb_wdata !== 8'h0) begin nerr++; $display("FAIL rst_data got %h exp 00", fb_wdata); end
    nchk++; if ({disp_on, disp_invert, disp_all_on} !== 3'b000) begin nerr++; $display("FAIL rst_flags got %b exp 000", {disp_on, disp_invert, disp_all_on}); end
    nchk++; if (contrast !== 8'h7F) begin nerr++; $display("FAIL rst_contrast got %h exp 7f", contrast); end
    release_reset();
    #1;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL ready got %b exp 1", in_ready); end
  endtask

  task automatic test_page_mode();
    for (int i = 0; i < 130; i++) begin
      push(1, 8'(i + 1));
      nchk++; if (fb_we !== 1'b1) begin nerr++; $display("FAIL page_we[%0d] got %b exp 1", i, fb_we); end
      nchk++; if (fb_waddr !== 10'(i % 128)) begin nerr++; $display("FAIL page_addr[%0d] got %h exp %h", i, fb_waddr, 10'(i % 128)); end
      nchk++; if (fb_wdata !== 8'(i + 1)) begin nerr++; $display("FAIL page_data[%0d] got %h exp %h", i, fb_wdata, 8'(i + 1)); end
    end
    idle();
    nchk++; if (fb_we !== 1'b0) begin nerr++; $display("FAIL page_we_pulse got %b exp 0", fb_we); end
    nchk++; if (disp_on !== 1'b0) begin nerr++; $display("FAIL page_disp_on got %b exp 0", disp_on); end
    nchk++; if (contrast !== 8'h7F) begin nerr++; $display("FAIL page_contrast got %h exp 7f", contrast); end
  endtask

  task automatic test_horiz();
    logic [7:0] cmds [8] = '{8'h20, 8'h00, 8'h21, 8'h10, 8'h11, 8'h22, 8'h02, 8'h03};
    logic [9:0] exp [5] = '{10'h110, 10'h111, 10'h190, 10'h191, 10'h110};
    foreach (cmds[i]) push(0, cmds[i]);
    for (int i = 0; i < 5; i++) begin
      push(1, 8'(8'hC0 + i));
      nchk++; if (fb_we !== 1'b1 || fb_waddr !== exp[i]) begin nerr++; $display("FAIL horiz[%0d] got we=%b addr=%h exp we=1 addr=%h", i, fb_we, fb_waddr, exp[i]); end
    end
  endtask

  task automatic test_vert();
    logic [7:0] cmds [8] = '{8'h20, 8'h01, 8'h21, 8'h05, 8'h06, 8'h22, 8'h06, 8'h07};
    logic [9:0] exp [5] = '{10'h305, 10'h385, 10'h306, 10'h386, 10'h305};
    foreach (cmds[i]) push(0, cmds[i]);
    for (int i = 0; i < 5; i++) begin
      push(1, 8'(8'hD0 + i));
      nchk++; if (fb_we !== 1'b1 || fb_waddr !== exp[i]) begin nerr++; $display("FAIL vert[%0d] got we=%b addr=%h exp we=1 addr=%h", i, fb_we, fb_waddr, exp[i]); end
    end
  endtask

  task automatic test_flags();
    logic [7:0] cmds [7] = '{8'hAF, 8'hA7, 8'hA5, 8'h81, 8'h33, 8'h8D, 8'h14};
    foreach (cmds[i]) push(0, cmds[i]);
    push(1, 8'h5C);
    nchk++; if (fb_we !== 1'b1 || fb_wdata !== 8'h5C) begin nerr++; $display("FAIL flags_write got we=%b data=%h exp we=1 data=5c", fb_we, fb_wdata); end
    nchk++; if (fb_waddr !== 10'h385) begin nerr++; $display("FAIL flags_addr got %h exp 385", fb_waddr); end
    nchk++; if ({disp_on, disp_invert, disp_all_on} !== 3'b111) begin nerr++; $display("FAIL flags_set got %b exp 111", {disp_on, disp_invert, disp_all_on}); end
    nchk++; if (contrast !== 8'h33) begin nerr++; $display("FAIL flags_contrast got %h exp 33", contrast); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cmds [5] = '{8'h20, 8'h02, 8'hB3, 8'h04, 8'h12};
    foreach (cmds[i]) push(0, cmds[i]);
    push(1, 8'hAA);
    nchk++; if (fb_we !== 1'b1 || fb_waddr !== 10'h1A4 || fb_wdata !== 8'hAA) begin nerr++; $display("FAIL nibble got we=%b addr=%h data=%h exp 1 1a4 aa", fb_we, fb_waddr, fb_wdata); end
    push(0, 8'h21);
    push(0, 8'h50);
    push(1, 8'h55);
    nchk++; if (fb_we !== 1'b1 || fb_waddr !== 10'h1D0 || fb_wdata !== 8'h55) begin nerr++; $display("FAIL abort got we=%b addr=%h data=%h exp 1 1d0 55", fb_we, fb_waddr, fb_wdata); end
    push(0, 8'hB0);
    push(1, 8'h66);
    nchk++; if (fb_waddr !== 10'h051) begin nerr++; $display("FAIL abort_cmd got %h exp 051", fb_waddr); end
    idle();
    nchk++; if (fb_we !== 1'b0) begin nerr++; $display("FAIL b2b_pulse got %b exp 0", fb_we); end
  endtask

  task automatic test_reset_mid();
    push(0, 8'hAF);
    push(1, 8'h77);
    nchk++; if (fb_we !== 1'b1) begin nerr++; $display("FAIL mid_we_pre got %b exp 1", fb_we); end
    hold_reset(1);
    nchk++; if (fb_we !== 1'b0) begin nerr++; $display("FAIL mid_we got %b exp 0", fb_we); end
    nchk++; if (fb_waddr !== 10'h0 || fb_wdata !== 8'h0) begin nerr++; $display("FAIL mid_bus got %h %h exp 000 00", fb_waddr, fb_wdata); end
    nchk++; if (disp_on !== 1'b0) begin nerr++; $display("FAIL mid_disp_on got %b exp 0", disp_on); end
    nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL mid_ready got %b exp 0", in_ready); end
    release_reset();
    push(0, 8'h81);
    hold_reset(1);
    release_reset();
    push(0, 8'hA5);
    nchk++; if (disp_all_on !== 1'b1 || contrast !== 8'h7F) begin nerr++; $display("FAIL mid_arg got all_on=%b contrast=%h exp 1 7f", disp_all_on, contrast); end
    push(1, 8'h09);
    nchk++; if (fb_waddr !== 10'h0) begin nerr++; $display("FAIL mid_ptr got %h exp 000", fb_waddr); end
  endtask

  task automatic test_random();
    logic [7:0] ops [16] = '{8'h20, 8'h21, 8'h22, 8'h81, 8'h8D, 8'hA4, 8'hA5, 8'hA6,
                             8'hA7, 8'hAE, 8'hAF, 8'hB2, 8'h05, 8'h13, 8'hD9, 8'hE3};
    logic [7:0] b;
    hold_reset(1);
    release_reset();
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0: idle();
        1, 2, 3, 4: push(1, 8'($urandom));
        default: begin
          b = (argn == 0 && $urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 15)] : 8'($urandom);
          push(0, b);
        end
      endcase
      nchk++; if (fb_we !== exp_we) begin nerr++; $display("FAIL rnd_we[%0d] got %b exp %b", n, fb_we, exp_we); end
      if (exp_we) begin
        nchk++; if (fb_waddr !== exp_addr || fb_wdata !== exp_data) begin nerr++; $display("FAIL rnd_write[%0d] got %h/%h exp %h/%h", n, fb_waddr, fb_wdata, exp_addr, exp_data); end
      end
      nchk++; if ({disp_on, disp_invert, disp_all_on, contrast} !== {m_on, m_inv, m_all, 8'(m_con)}) begin nerr++; $display("FAIL rnd_state[%0d] got %b%b%b/%h exp %b%b%b/%h", n, disp_on, disp_invert, disp_all_on, contrast, m_on, m_inv, m_all, 8'(m_con)); end
      nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rnd_ready[%0d] got %b exp 1", n, in_ready); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_page_mode();
    test_horiz();
    test_vert();
    test_flags();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
